// File: rtl/instruction_queue.sv
// Show-ahead instruction/PC FIFO between fetch and decode/dispatch.
// The head entry is presented combinationally and zeroed whenever the queue is empty.
module instruction_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_pc,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [INST_W-1:0] pop_inst,
  output logic [PC_W-1:0]   pop_pc,
  output logic [6:0]        pop_opcode,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  // Handshakes: a transfer fires on a cycle where valid && ready are both high at
  // the rising edge; the sender holds its payload stable while valid is high and
  // ready is low. Ready/valid here depend on registered count only.

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              push_fire;
  logic              pop_fire;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_fire) wp <= wp + 1'b1;
      if (pop_fire)  rp <= rp + 1'b1;
      if (push_fire && !pop_fire)      count <= count + 1'b1;
      else if (pop_fire && !push_fire) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left unreset; outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      mem_inst[wp] <= push_inst;
      mem_pc[wp]   <= push_pc;
    end
  end

  always_comb begin
    pop_inst   = '0;
    pop_pc     = '0;
    pop_opcode = '0;
    if (!empty) begin
      pop_inst   = mem_inst[rp];
      pop_pc     = mem_pc[rp];
      pop_opcode = mem_inst[rp][6:0];
    end
  end

endmodule
